// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: a shared tick prescaler and frame counter drive
// per-channel pulses. Duty, slew and enable changes are applied only at frame boundaries.
module servo_pwm_array #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 128_000,
  parameter int unsigned PERIOD_TICKS = 2560,
  parameter int unsigned DUTY_W       = 8,
  parameter int unsigned MIN_TICKS    = 128,
  parameter int unsigned STEP         = 0
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic [CHANNELS-1:0] wr_en_i,
  input  logic [DUTY_W-1:0]   wr_duty_i,
  input  logic [CHANNELS-1:0] enable_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic [CHANNELS-1:0] settled_o,
  output logic                frame_start_o
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FRAME_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int unsigned CMP_W   = FRAME_W + 1;
  localparam int unsigned SLEW_W  = DUTY_W + 1;

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (MIN_TICKS + (2 ** DUTY_W) - 1 >= PERIOD_TICKS) begin : g_bad_period
    $error("MIN_TICKS + 2**DUTY_W - 1 must be below PERIOD_TICKS");
  end

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               tick;
  logic               boundary;

  logic [DUTY_W-1:0]   target_q [CHANNELS];
  logic [DUTY_W-1:0]   target_d [CHANNELS];
  logic [DUTY_W-1:0]   active_q [CHANNELS];
  logic [DUTY_W-1:0]   active_d [CHANNELS];
  logic [CHANNELS-1:0] en_lat_q, en_lat_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] settled_q, settled_d;
  logic                frame_start_q;

  // Move active toward target by at most STEP; one extra bit keeps the difference from wrapping.
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] act,
                                              input logic [DUTY_W-1:0] tgt);
    logic [SLEW_W-1:0] a;
    logic [SLEW_W-1:0] t;
    logic [SLEW_W-1:0] diff;
    a    = SLEW_W'(act);
    t    = SLEW_W'(tgt);
    diff = (t >= a) ? (t - a) : (a - t);
    if (STEP == 0 || 32'(diff) <= STEP) begin
      slew = tgt;
    end else if (t > a) begin
      slew = DUTY_W'(a + SLEW_W'(STEP));
    end else begin
      slew = DUTY_W'(a - SLEW_W'(STEP));
    end
  endfunction

  // Shared prescaler and frame counter.
  always_comb begin
    tick        = (tick_cnt_q == TICK_W'(DIV - 1));
    boundary    = tick && (frame_cnt_q == FRAME_W'(PERIOD_TICKS - 1));
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = boundary ? '0 : frame_cnt_q + FRAME_W'(1);
    end
  end

  // Per-channel next state; pwm uses post-edge values so it lines up with frame_cnt.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      target_d[i]  = wr_en_i[i] ? wr_duty_i : target_q[i];
      active_d[i]  = boundary ? slew(active_q[i], target_q[i]) : active_q[i];
      en_lat_d[i]  = boundary ? enable_i[i] : en_lat_q[i];
      pwm_d[i]     = en_lat_d[i] &&
                     (CMP_W'(frame_cnt_d) < CMP_W'(MIN_TICKS) + CMP_W'(active_d[i]));
      settled_d[i] = (active_d[i] == target_d[i]);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tick_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      en_lat_q      <= '0;
      pwm_q         <= '0;
      settled_q     <= '1;
      frame_start_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        target_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      en_lat_q      <= en_lat_d;
      pwm_q         <= pwm_d;
      settled_q     <= settled_d;
      frame_start_q <= boundary;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        target_q[i] <= target_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_o         = pwm_q;
  assign settled_o     = settled_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: per-frame pulse widths are measured and checked against
// a queue of expected frames; a second instance runs with slew limiting enabled.
module tb_servo_pwm_array;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] wr_en, wr_en_s, wr_duty, enable, enable_s;
  logic [3:0] pwm, settled, pwm_s, settled_s;
  logic       frame_start, frame_start_s;

  always #5 clock = ~clock;

  servo_pwm_array #(.CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(500), .PERIOD_TICKS(64),
                    .DUTY_W(4), .MIN_TICKS(8), .STEP(0)) dut (
    .clock_i(clock), .reset_ni(reset_n), .wr_en_i(wr_en), .wr_duty_i(wr_duty),
    .enable_i(enable), .pwm_o(pwm), .settled_o(settled), .frame_start_o(frame_start));

  servo_pwm_array #(.CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(500), .PERIOD_TICKS(64),
                    .DUTY_W(4), .MIN_TICKS(8), .STEP(4)) dut_s (
    .clock_i(clock), .reset_ni(reset_n), .wr_en_i(wr_en_s), .wr_duty_i(wr_duty),
    .enable_i(enable_s), .pwm_o(pwm_s), .settled_o(settled_s), .frame_start_o(frame_start_s));

  // w[0..3]: widths of the STEP=0 channels, w[4]: width of the slewed channel 0.
  typedef logic [4:0][7:0] widths_t;
  typedef struct packed {
    widths_t    w;
    logic [3:0] set_d;
    logic [3:0] set_s;
  } exp_t;
  typedef struct {
    int         act_at;
    logic [3:0] wr_en;
    logic [3:0] wr_duty;
    logic       wr_s;
    logic [3:0] en;
    exp_t       exp;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];
  exp_t exp_q [$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   in_frame = 1'b0;
  int   cnt [5];
  int   cyc = 0;
  int   frame_no = 0;
  logic [3:0] snap_d, snap_s;

  function automatic exp_t mk(int a, int b, int c, int d, int s,
                              logic [3:0] sd, logic [3:0] ss);
    exp_t r;
    r.w[0] = 8'(a); r.w[1] = 8'(b); r.w[2] = 8'(c); r.w[3] = 8'(d); r.w[4] = 8'(s);
    r.set_d = sd;
    r.set_s = ss;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no frame_start within the cycle budget", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Frame monitor: count pwm-high cycles between frame_start pulses, then score.
  always @(negedge clock) begin
    if (!reset_n) begin
      in_frame = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_frame) begin
          if (exp_q.size() == 0) begin
            check($sformatf("frame%0d expectation present", frame_no), 0, 1);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 5; i++)
              check($sformatf("frame%0d width ch%0d", frame_no, i), cnt[i], int'(e.w[i]));
            check($sformatf("frame%0d settled", frame_no), int'(snap_d), int'(e.set_d));
            check($sformatf("frame%0d settled_step", frame_no), int'(snap_s), int'(e.set_s));
            check($sformatf("frame%0d spacing", frame_no), cyc, 128);
          end
        end
        in_frame = mon_en;
        cyc      = 0;
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        snap_d   = settled;
        snap_s   = settled_s;
        frame_no++;
      end
      cyc++;
      for (int i = 0; i < 4; i++) cnt[i] += int'(pwm[i]);
      cnt[4] += int'(pwm_s[0]);
    end
  end

  // Reset was released on a negedge; the first boundary must land on rising edge 128 with no pulses before.
  task automatic check_silent(input string tag);
    int n;
    int hi;
    n  = 0;
    hi = 0;
    do begin
      @(negedge clock);
      n++;
      if (!frame_start) hi += $countones(pwm) + $countones(pwm_s);
    end while (!frame_start && n < 300);
    if (!frame_start) finish_now({tag, " first boundary"});
    check({tag, " first boundary edge"}, n, 128);
    check({tag, " silent first frame"}, hi, 0);
  endtask

  // Starts at a frame_start negedge; returns at the next one.
  task automatic run_frame(input vec_t v, input bit last);
    int n;
    n = 0;
    exp_q.push_back(v.exp);
    while (n < v.act_at) begin
      @(negedge clock);
      n++;
    end
    wr_en   = v.wr_en;
    wr_duty = v.wr_duty;
    wr_en_s = {3'b000, v.wr_s};
    enable  = v.en;
    if (last) mon_en = 1'b0;
    @(negedge clock);
    n++;
    wr_en   = '0;
    wr_en_s = '0;
    while (!frame_start && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!frame_start) finish_now("run_frame");
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    wr_en    = '0;
    wr_en_s  = '0;
    wr_duty  = '0;
    enable   = '0;
    enable_s = 4'hF;

    // Frame 1 writes ch0/ch2 (and slewed ch0) mid-frame; frame 3 drops enable[1] 4 clocks
    // into its pulse; frame 4 writes ch3 on the boundary edge itself.
    tbl[0] = '{20,  4'b0101, 4'd15, 1'b1, 4'b1111, mk(16, 16, 16, 16, 16, 4'b1111, 4'b1111)};
    tbl[1] = '{20,  4'b0000, 4'd0,  1'b0, 4'b1111, mk(46, 16, 46, 16, 24, 4'b1111, 4'b1110)};
    tbl[2] = '{4,   4'b0000, 4'd0,  1'b0, 4'b1101, mk(46, 16, 46, 16, 32, 4'b1111, 4'b1110)};
    tbl[3] = '{127, 4'b1000, 4'd7,  1'b0, 4'b1101, mk(46, 0,  46, 16, 40, 4'b1111, 4'b1110)};
    tbl[4] = '{20,  4'b0000, 4'd0,  1'b0, 4'b1101, mk(46, 0,  46, 16, 46, 4'b0111, 4'b1111)};
    tbl[5] = '{20,  4'b0000, 4'd0,  1'b0, 4'b1101, mk(46, 0,  46, 30, 46, 4'b1111, 4'b1111)};

    repeat (3) @(negedge clock);
    check("reset pwm", int'(pwm), 0);
    check("reset pwm_step", int'(pwm_s), 0);
    check("reset settled", int'(settled), 15);
    check("reset settled_step", int'(settled_s), 15);
    check("reset frame_start", int'(frame_start), 0);

    enable  = 4'hF;
    mon_en  = 1'b1;
    reset_n = 1'b1;
    check_silent("boot");

    for (int f = 0; f < NV; f++) run_frame(tbl[f], f == NV - 1);

    // Mid-pulse asynchronous reset.
    repeat (5) @(negedge clock);
    check("pre-reset pwm", int'(pwm), 13);
    check("pre-reset pwm_step", int'(pwm_s), 15);
    reset_n = 1'b0;
    #1;
    check("async reset pwm", int'(pwm), 0);
    check("async reset pwm_step", int'(pwm_s), 0);
    check("async reset frame_start", int'(frame_start), 0);
    check("async reset settled", int'(settled), 15);
    repeat (3) @(negedge clock);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    check_silent("post-reset");

    exp_q.push_back(mk(16, 0, 16, 16, 16, 4'b1111, 4'b1111));
    repeat (30) @(negedge clock);
    mon_en = 1'b0;
    n = 30;
    while (!frame_start && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!frame_start) finish_now("final frame");
    @(negedge clock);
    check("scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_array.md
# servo_pwm_array

Multi-channel hobby-servo PWM generator: one shared tick prescaler and one shared frame counter drive CHANNELS pulse outputs. Each channel has its own duty target, enable and optional slew-rate limiter. All changes take effect only at frame boundaries, so no output ever produces a runt or stretched pulse. The block sits between the board-level register/switch logic and the servo header pins, and supersedes the fixed 4-channel, fixed-period controller.

## Interface
- CHANNELS, 4: number of independent PWM outputs (1..32).
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 128_000: PWM resolution tick rate. DIV = CLK_HZ/TICK_HZ; the result must be an integer ≥ 2.
- PERIOD_TICKS, 2560: frame length in ticks (20 ms at the defaults).
- DUTY_W, 8: duty word width.
- MIN_TICKS, 128: pulse width for duty 0 (1 ms at the defaults). Constraint: MIN_TICKS + 2^DUTY_W − 1 < PERIOD_TICKS.
- STEP, 0: maximum change of the active duty per frame. 0 disables slew limiting.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  CHANNELS  per-channel write strobe; a channel loads wr_duty into its target when its bit is 1.
- wr_duty  in  DUTY_W  duty value shared by all write strobes.
- enable  in  CHANNELS  per-channel output enable, sampled at frame boundaries only.
- pwm  out  CHANNELS  servo pulse outputs, registered.
- settled  out  CHANNELS  1 when the channel's active duty equals its target.
- frame_start  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Prescaler:** tick_cnt counts 0..DIV−1 and wraps. The internal `tick` is asserted when tick_cnt == DIV−1.
- **Frame counter:** frame_cnt has width clog2(PERIOD_TICKS). It advances only on edges where `tick` is asserted, and wraps from PERIOD_TICKS−1 to 0.
- **Boundary event:** `tick` && frame_cnt == PERIOD_TICKS−1. On that edge, for each channel:
  - en_lat[i] <= enable[i].
  - active[i] update:
    - STEP == 0: active[i] <= target[i].
    - |target[i] − active[i]| ≤ STEP: active[i] <= target[i].
    - Otherwise: active[i] moves by ±STEP toward target[i].
  - Slew arithmetic is done at DUTY_W+1 bits, so it never wraps.
- **Writes:** target[i] <= wr_duty on any edge where wr_en[i] = 1, regardless of frame position.
  - Several strobes in the same cycle load the same value into each selected channel.
  - A write on the boundary edge does not affect that boundary's update; the boundary uses the pre-write target, and the new target applies at the next boundary.
- **Output:** pwm[i] is high exactly when en_lat[i] && frame_cnt < MIN_TICKS + active[i], where frame_cnt and active are the post-edge values.
  - The register is computed from next-state values, so pwm and frame_cnt change on the same edge.
  - Pulse width in clocks = (MIN_TICKS + active[i]) × DIV.
- **settled[i]** = (active[i] == target[i]), decoded from registers.
- **frame_start** is registered and high for the single cycle after a boundary edge, aligned with the pwm rising edges.
- **Enable changes:** deasserting enable mid-frame does not truncate the current pulse; the output goes silent from the next frame. Asserting enable mid-frame produces nothing until the next frame.

## Timing
- **Reset values:** tick_cnt = 0, frame_cnt = 0, target = 0, active = 0, en_lat = 0, pwm = 0, frame_start = 0, settled = all 1.
- **Reset assertion:** asynchronous. pwm drops to 0 immediately, including mid-pulse.
- **After reset release:**
  - The first frame is silent, because en_lat = 0.
  - The first boundary edge is the (DIV × PERIOD_TICKS)-th rising edge.
  - The first pulse starts on that edge.
- **Write-to-pulse latency:** the new width appears at the first boundary after the write edge, between 1 and DIV × PERIOD_TICKS clocks later.
- **Slew:** with STEP > 0, reaching the target takes ceil(|Δ| / STEP) frames. settled rises on the boundary edge that makes active equal to target.
- **Frame period:** exactly DIV × PERIOD_TICKS clocks, with no drift.

## Test plan
Bench parameters unless stated: CLK_HZ = 1000, TICK_HZ = 500 (DIV = 2), PERIOD_TICKS = 64, MIN_TICKS = 8, DUTY_W = 4, CHANNELS = 4, STEP = 0.
1. **Reset, then enable all, no writes:**
   - Frame 0: all pwm = 0.
   - From frame 1: every pwm pulse is 16 clocks.
   - frame_start spacing is 128 clocks.
2. **Write wr_en = 4'b0101, wr_duty = 15 mid-frame:**
   - The current frame is unchanged.
   - Next frame: ch0/ch2 pulse 46 clocks, ch1/ch3 pulse 16 clocks.
3. **Write coincident with a boundary edge:**
   - The frame that starts on that edge keeps the old width.
   - The following frame uses the new width.
4. **STEP = 4, target 0→15:**
   - Successive frames have active = 4, 8, 12, 15, i.e. pulse widths 24, 32, 40, 46 clocks.
   - settled = 0 until the 4th boundary, then 1.
5. **Deassert enable[1] 4 clocks into its pulse:**
   - The current pulse completes at full width.
   - The next frame has ch1 = 0; other channels are unaffected.
6. **Assert reset_n = 0 mid-pulse:**
   - pwm = 0 in the same cycle.
   - After release, all state is at reset values and the first frame is silent.
